// File: rtl/alu.sv
// Registered signed ALU: add, subtract, multiply and absolute difference of two 6-bit operands.
// Optional macro ALU_MUL_SAT_EN saturates out-of-range products; otherwise they wrap to 8 bits.
module alu (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] out,
    output logic       ovf,
    input  logic [5:0] A,
    input  logic [5:0] B,
    input  logic [1:0] C
);

    logic signed [7:0]  a_ext;
    logic signed [7:0]  b_ext;
    logic signed [11:0] a_wide;
    logic signed [11:0] b_wide;
    logic signed [11:0] prod;
    logic signed [7:0]  sum;
    logic signed [7:0]  diff;
    logic signed [7:0]  abs_diff;
    logic               prod_high;
    logic               prod_low;

    logic [7:0] out_reg;
    logic [7:0] out_next;
    logic       ovf_reg;
    logic       ovf_next;

    assign a_ext  = {{2{A[5]}}, A};
    assign b_ext  = {{2{B[5]}}, B};
    assign a_wide = {{6{A[5]}}, A};
    assign b_wide = {{6{B[5]}}, B};

    // 8 bits hold every sum and difference of two 6-bit operands exactly.
    assign sum      = a_ext + b_ext;
    assign diff     = a_ext - b_ext;
    assign abs_diff = diff[7] ? -diff : diff;

    // 12 bits hold the full product, so the single-cycle multiply never loses precision.
    assign prod      = a_wide * b_wide;
    assign prod_high = prod > 12'sd127;
    assign prod_low  = prod < -12'sd128;

    always_comb begin
        out_next = 8'h00;
        ovf_next = 1'b0;
        case (C)
            2'b00: out_next = sum;
            2'b01: out_next = diff;
            2'b10: begin
                ovf_next = prod_high | prod_low;
`ifdef ALU_MUL_SAT_EN
                if (prod_high)
                    out_next = 8'h7F;
                else if (prod_low)
                    out_next = 8'h80;
                else
                    out_next = prod[7:0];
`else
                out_next = prod[7:0];
`endif
            end
            default: out_next = abs_diff;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_reg <= 8'h00;
            ovf_reg <= 1'b0;
        end else begin
            out_reg <= out_next;
            ovf_reg <= ovf_next;
        end
    end

    assign out = out_reg;
    assign ovf = ovf_reg;

endmodule

// File: tb/tb_alu.sv
// Directed and randomized checks of the registered ALU; expectations are queued when driven
// and popped one clock later when the registered result is visible.
module tb_alu;

    logic       clk;
    logic       rst;
    logic [7:0] out;
    logic       ovf;
    logic [5:0] A;
    logic [5:0] B;
    logic [1:0] C;

    typedef struct packed {
        logic [7:0] out;
        logic       ovf;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    vectors;
    int    miscompares;

    alu dut (
        .clk (clk),
        .rst (rst),
        .out (out),
        .ovf (ovf),
        .A   (A),
        .B   (B),
        .C   (C)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    // Drive one vector, queue its expectation, then compare once the register has updated.
    task automatic apply(input string tag, input logic [5:0] a, input logic [5:0] b,
                         input logic [1:0] c, input logic r,
                         input logic [7:0] e_out, input logic e_ovf);
        exp_t e;
        exp_t got;
        string t;
        @(negedge clk);
        A   = a;
        B   = b;
        C   = c;
        rst = r;
        exp_q.push_back({e_out, e_ovf});
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        e   = exp_q.pop_front();
        t   = tag_q.pop_front();
        got = {out, ovf};
        vectors++;
        $display("vec %0s: rst=%b A=%0d B=%0d C=%b -> out=%h ovf=%b (exp %h %b)",
                 t, r, $signed(a), $signed(b), c, out, ovf, e.out, e.ovf);
        assert (got === e) else begin
            miscompares++;
            $error("FAIL %0s: out=%h ovf=%b, expected out=%h ovf=%b",
                   t, out, ovf, e.out, e.ovf);
        end
    endtask

    // Reference model built from plain integer arithmetic.
    function automatic exp_t model(input int a, input int b, input logic [1:0] c);
        exp_t r;
        int   v;
        int   d;
        r.ovf = 1'b0;
        d = a - b;
        case (c)
            2'b00: v = a + b;
            2'b01: v = d;
            2'b10: begin
                v = a * b;
                if (v > 127 || v < -128) begin
                    r.ovf = 1'b1;
`ifdef ALU_MUL_SAT_EN
                    v = (v > 127) ? 127 : -128;
`endif
                end
            end
            default: v = (d < 0) ? -d : d;
        endcase
        r.out = v[7:0];
        return r;
    endfunction

    localparam logic [7:0] MUL_10_13 =
`ifdef ALU_MUL_SAT_EN
        8'h7F;
`else
        8'h82;
`endif
    localparam logic [7:0] MUL_POS_EXT =
`ifdef ALU_MUL_SAT_EN
        8'h7F;
`else
        8'h00;
`endif
    localparam logic [7:0] MUL_NEG_EXT =
`ifdef ALU_MUL_SAT_EN
        8'h80;
`else
        8'h20;
`endif

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst = 1'b1;
        A   = 6'd0;
        B   = 6'd0;
        C   = 2'b00;

        apply("reset1", 6'd10, 6'd13, 2'b00, 1'b1, 8'h00, 1'b0);
        apply("reset2", 6'd10, 6'd13, 2'b00, 1'b1, 8'h00, 1'b0);
        apply("post_reset_add", 6'd10, 6'd13, 2'b00, 1'b0, 8'd23, 1'b0);

        apply("add_10_13", 6'd10, 6'd13, 2'b00, 1'b0, 8'd23, 1'b0);
        apply("sub_10_13", 6'd10, 6'd13, 2'b01, 1'b0, 8'hFD, 1'b0);
        apply("mul_10_13", 6'd10, 6'd13, 2'b10, 1'b0, MUL_10_13, 1'b1);
        apply("abs_10_13", 6'd10, 6'd13, 2'b11, 1'b0, 8'd3, 1'b0);

        apply("add_3_31", 6'd3, 6'd31, 2'b00, 1'b0, 8'd34, 1'b0);
        apply("sub_3_31", 6'd3, 6'd31, 2'b01, 1'b0, 8'hE4, 1'b0);
        apply("mul_3_31", 6'd3, 6'd31, 2'b10, 1'b0, 8'd93, 1'b0);
        apply("abs_3_31", 6'd3, 6'd31, 2'b11, 1'b0, 8'd28, 1'b0);

        apply("mul_m32_m32", 6'h20, 6'h20, 2'b10, 1'b0, MUL_POS_EXT, 1'b1);
        apply("mul_m32_31", 6'h20, 6'd31, 2'b10, 1'b0, MUL_NEG_EXT, 1'b1);

        apply("add_m32_m32", 6'h20, 6'h20, 2'b00, 1'b0, 8'hC0, 1'b0);
        apply("sub_m32_31", 6'h20, 6'd31, 2'b01, 1'b0, 8'hC1, 1'b0);
        apply("abs_m32_31", 6'h20, 6'd31, 2'b11, 1'b0, 8'd63, 1'b0);

        apply("mid_reset_mul", 6'd5, 6'd7, 2'b10, 1'b1, 8'h00, 1'b0);
        apply("after_mid_reset", 6'd1, 6'd1, 2'b00, 1'b0, 8'd2, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [5:0] ra;
            logic [5:0] rb;
            logic [1:0] rc;
            exp_t       m;
            ra = 6'($urandom_range(0, 63));
            rb = 6'($urandom_range(0, 63));
            rc = 2'($urandom_range(0, 3));
            m  = model($signed(ra), $signed(rb), rc);
            apply("random", ra, rb, rc, 1'b0, m.out, m.ovf);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
